// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave datapath.
package spi_pkg;

    localparam int RAM_MEM_DEPTH = 256;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } ram_cmd_e;

    typedef enum logic {
        RAM_IDLE,
        RAM_TX
    } ram_state_e;

endpackage

// File: rtl/ram_array.sv
// Byte-wide storage with synchronous write and synchronous read.
// There is no reset, so contents survive a controller reset.
module ram_array
    import spi_pkg::*;
#(
    parameter int DEPTH = RAM_MEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Write port; the read register holds its value until the next read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spi_ram.sv
// Command-driven byte memory behind the SPI slave.
//
//   state    | meaning
//   RAM_IDLE | no read byte presented to the slave
//   RAM_TX   | tx_data holds a read byte, tx_valid high
module spi_ram
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = RAM_MEM_DEPTH,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       cmd_err
);

    ram_state_e           state;
    ram_cmd_e             cmd;
    logic                 rx_valid_q;
    logic                 accept;
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic                 wr_vld;
    logic                 rd_vld;
    logic                 tx_zero;
    logic                 we;
    logic                 re;
    logic [7:0]           rdata;

    assign cmd    = ram_cmd_e'(rx_data[9:8]);
    assign accept = rx_valid && !rx_valid_q;

    // Reset blocks array access so a command in the reset cycle is lost.
    assign we = !rst && accept && (cmd == WR_DATA) && wr_vld;
    assign re = !rst && accept && (cmd == RD_DATA) && rd_vld;

    ram_array #(
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_SIZE)
    ) u_ram_array (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (rx_data[7:0]),
        .re    (re),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // The array read register is the tx_data register; it only changes on a
    // read, so it stays constant through TX and after leaving TX. Since the
    // array has no reset, tx_zero forces a zero until the first read.
    assign tx_data  = tx_zero ? 8'h00 : rdata;
    assign tx_valid = (state == RAM_TX);

    // Edge detect, command decode, pointer update and FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RAM_IDLE;
            rx_valid_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_vld     <= 1'b0;
            rd_vld     <= 1'b0;
            cmd_err    <= 1'b0;
            tx_zero    <= 1'b1;
        end else begin
            rx_valid_q <= rx_valid;
            cmd_err    <= 1'b0;
            if (accept) begin
                state <= RAM_IDLE;
                unique case (cmd)
                    WR_ADDR: begin
                        wr_ptr <= rx_data[ADDR_SIZE-1:0];
                        wr_vld <= 1'b1;
                    end
                    WR_DATA: begin
                        if (wr_vld) begin
                            wr_ptr <= wr_ptr + ADDR_SIZE'(1);
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                    RD_ADDR: begin
                        rd_ptr <= rx_data[ADDR_SIZE-1:0];
                        rd_vld <= 1'b1;
                    end
                    RD_DATA: begin
                        if (rd_vld) begin
                            rd_ptr  <= rd_ptr + ADDR_SIZE'(1);
                            state   <= RAM_TX;
                            tx_zero <= 1'b0;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/spi_ram.md
# spi_ram

Single-port, byte-wide command-driven memory that sits directly downstream of the SPI slave. It consumes the slave's 10-bit `rx_data`/`rx_valid` words, decodes the 2-bit command prefix, and performs write-address, write-data, read-address and read-data operations. Read data goes back to the slave on `tx_data`/`tx_valid` for shifting out on MISO. Read and write address pointers are independent and auto-incrementing, so bursts need only one address command.

## Interface
- `MEM_DEPTH`, default 256: number of byte locations; must be a power of two, ≤ 256.
- `ADDR_SIZE`, default 8: pointer width; must equal $clog2(MEM_DEPTH).
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  10  command word from the SPI slave: [9:8] command, [7:0] payload.
- `rx_valid`  in  1  level from the SPI slave; high while `rx_data` holds a word and may stay high for many cycles.
- `tx_data`  out  8  read data to the SPI slave.
- `tx_valid`  out  1  `tx_data` is valid and stable.
- `cmd_err`  out  1  one-cycle pulse: data command issued without a loaded pointer.

## Operation
- **Command acceptance.** A command is accepted only on the `rx_valid` rising edge: `rx_valid` = 1 and the registered `rx_valid_q` = 0. Exactly one command is accepted per assertion, regardless of how long `rx_valid` stays high.
- **Decode of `rx_data[9:8]`:**
  - 00 WR_ADDR: `wr_ptr` <= `rx_data[ADDR_SIZE-1:0]`; `wr_vld` <= 1.
  - 01 WR_DATA, if `wr_vld`: `mem[wr_ptr]` <= `rx_data[7:0]`; `wr_ptr` <= `wr_ptr`+1. If not `wr_vld`: no write, `cmd_err` pulse.
  - 10 RD_ADDR: `rd_ptr` <= `rx_data[ADDR_SIZE-1:0]`; `rd_vld` <= 1. Any active `tx_valid` is dropped.
  - 11 RD_DATA, if `rd_vld`: `tx_data` <= `mem[rd_ptr]`; `rd_ptr` <= `rd_ptr`+1; enter TX. If not `rd_vld`: `cmd_err` pulse and `tx_valid` = 0. The payload is ignored.
- **Pointers.** Pointer increments are modulo MEM_DEPTH (wrap MEM_DEPTH-1 -> 0). Payload bits above ADDR_SIZE are ignored.
- **FSM, states IDLE and TX:**
  - IDLE -> TX on accepted valid RD_DATA.
  - TX -> TX on another accepted valid RD_DATA; `tx_data` updates and `tx_valid` stays 1.
  - TX -> IDLE on any other accepted command, including an erroneous RD_DATA.
  - `rx_valid` activity without a rising edge never changes state.
  - `tx_valid` = (state == TX). `tx_data` is held constant for the whole TX stay between accepts.
- **Memory.** The array is not cleared by `rst`. Reading a location that was never written returns an undefined value. Benches must write before reading.
- **Reset values:**
  - `tx_data` = 0, `tx_valid` = 0, `cmd_err` = 0.
  - state = IDLE.
  - `wr_ptr` = `rd_ptr` = 0, `wr_vld` = `rd_vld` = 0, `rx_valid_q` = 0.
- **Reset priority.** Reset mid-operation, including during TX, overrides any same-cycle command. The command is lost.
- **Reset with `rx_valid` held high.** `rx_valid_q` resets to 0, so if `rx_valid` is still high on the first post-reset edge, that edge is treated as a rising edge and accepted.

## Timing
- **Command latency.** A rising edge sampled at posedge k updates pointers and memory at posedge k. `tx_data`/`tx_valid`/`cmd_err` are visible in cycle k+1.
- **`cmd_err`** is high for exactly one cycle, k+1.
- **WR_DATA then RD_DATA to the same location.** The write completes at posedge k, so a later RD_DATA accepted at posedge ≥ k+1 returns the new byte. Two accepts cannot share a posedge.
- **`tx_valid` hold.** `tx_valid` stays high indefinitely until the next accepted command or `rst`. The SPI slave may take ≥ 10 cycles to shift the byte.
- **Throughput.** At most one command per `rx_valid` low->high transition; `rx_valid` must be low for ≥ 1 cycle between words.

## Structure
- **`spi_pkg` additions:**
  - `typedef enum logic [1:0] {WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11} ram_cmd_e;`
  - `typedef enum logic {RAM_IDLE, RAM_TX} ram_state_e;`
  - default MEM_DEPTH constant.
- **Sub-module `ram_array`:** a plain synchronous-write, synchronous-read byte array with ports `clk`, `we`, `waddr`, `wdata`, `re`, `raddr`, `rdata`. It has no reset. `spi_ram` holds the decode, pointers, edge detect and FSM.

## Test plan
- **Write then read:** reset; 0x0_12 (WR_ADDR 0x12), 0x1_AB (WR_DATA 0xAB), 0x2_12 (RD_ADDR 0x12), 0x3_00 (RD_DATA) -> `tx_data` = 0xAB, `tx_valid` = 1 from the cycle after the RD_DATA edge until the next accepted command.
- **Burst with wrap:** WR_ADDR 0xFE, WR_DATA 0x11, 0x22, 0x33 -> locations 0xFE = 0x11, 0xFF = 0x22, 0x00 = 0x33. RD_ADDR 0xFE, then three RD_DATA -> `tx_data` 0x11, 0x22, 0x33, with `tx_valid` staying 1 throughout.
- **Error path:** after reset, WR_DATA 0x55 -> `cmd_err` one-cycle pulse, no write. RD_DATA -> `cmd_err` pulse, `tx_valid` = 0.
- **Level hold:** `rx_valid` held high 12 cycles with WR_DATA 0x77 after WR_ADDR 0x10 -> exactly one write; `wr_ptr` = 0x11 afterwards.
- **TX exit:** in TX, accept WR_ADDR 0x20 -> `tx_valid` = 0 the next cycle and `tx_data` unchanged.
- **Mid-TX reset:** assert `rst` while `tx_valid` = 1 -> next cycle `tx_valid` = 0, `tx_data` = 0. RD_DATA with no new RD_ADDR -> `cmd_err`. Memory still holds previously written bytes.
